// File: rtl/servo_ref_counter_ar.sv
`default_nettype none
// ============================================================================
// Module   : servo_ref_counter_ar
// Brief    : Servo angle reference counter with edge-triggered stepping,
//            hold-to-auto-repeat, saturating clamp window and preset load.
// Revision : 1.0
// ============================================================================
module servo_ref_counter_ar #(
    parameter int WIDTH      = 9,
    parameter int STEP       = 5,
    parameter int MIN_VAL    = 20,
    parameter int MAX_VAL    = 340,
    parameter int INIT_VAL   = 180,
    parameter int HOLD_TICKS = 50,
    parameter int RATE_TICKS = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENA,
    input  logic             UP,
    input  logic             DOWN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] CUENTA,
    output logic             BANDERAENAUP,
    output logic             BANDERAENADOWN,
    output logic             CHANGED
);

    localparam int c_tick_max = (HOLD_TICKS > RATE_TICKS) ? HOLD_TICKS : RATE_TICKS;
    localparam int c_cnt_w    = $clog2(c_tick_max + 1);

    localparam logic [WIDTH:0]     c_step_x = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]     c_min_x  = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0]     c_max_x  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0]   c_step   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   c_min    = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0]   c_max    = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0]   c_init   = WIDTH'(INIT_VAL);
    localparam logic [c_cnt_w-1:0] c_hold   = c_cnt_w'(HOLD_TICKS);
    localparam logic [c_cnt_w-1:0] c_rate   = c_cnt_w'(RATE_TICKS);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_INC  = 2'd1,
        DIR_DEC  = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [WIDTH-1:0]   r_cuenta;
    logic               r_changed;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    dir_t               r_prev_dir;

    dir_t               w_dir;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    dir_t               w_prev_nxt;
    logic [WIDTH-1:0]   w_cuenta_nxt;
    logic               w_do_step;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_inc;
    logic [WIDTH-1:0]   w_dec;
    logic [WIDTH-1:0]   w_stepped;
    logic [WIDTH-1:0]   w_load_clamped;

    always_comb begin
        w_dir = DIR_NONE;
        if (UP && !DOWN)
            w_dir = DIR_INC;
        else if (DOWN && !UP)
            w_dir = DIR_DEC;
    end

    // Saturating step arithmetic, one bit wider so the sum cannot wrap.
    assign w_sum     = {1'b0, r_cuenta} + c_step_x;
    assign w_inc     = (w_sum > c_max_x) ? c_max : w_sum[WIDTH-1:0];
    assign w_dec     = ({1'b0, r_cuenta} < (c_min_x + c_step_x)) ? c_min : (r_cuenta - c_step);
    assign w_stepped = (w_dir == DIR_INC) ? w_inc : w_dec;

    assign w_load_clamped = (LOAD_VAL < c_min) ? c_min :
                            (LOAD_VAL > c_max) ? c_max : LOAD_VAL;

    assign w_cnt_inc = r_cnt + c_one;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_prev_nxt   = r_prev_dir;
        w_cuenta_nxt = r_cuenta;
        w_do_step    = 1'b0;
        if (LOAD) begin
            // Latching the live direction forces a release before the next step.
            w_cuenta_nxt = w_load_clamped;
            w_state_nxt  = ST_IDLE;
            w_cnt_nxt    = '0;
            w_prev_nxt   = w_dir;
        end else if (ENA) begin
            w_prev_nxt = w_dir;
            case (r_state)
                ST_IDLE: begin
                    if (w_dir != DIR_NONE && w_dir != r_prev_dir) begin
                        w_do_step   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (w_dir == DIR_NONE) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_dir != r_prev_dir) begin
                        w_do_step   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_HOLD;
                    end else if (w_cnt_inc == ((r_state == ST_HOLD) ? c_hold : c_rate)) begin
                        w_do_step   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
            if (w_do_step)
                w_cuenta_nxt = w_stepped;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cuenta   <= c_init;
            r_changed  <= 1'b0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_prev_dir <= DIR_NONE;
        end else begin
            r_cuenta   <= w_cuenta_nxt;
            r_changed  <= (w_cuenta_nxt != r_cuenta);
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_prev_dir <= w_prev_nxt;
        end
    end

    assign CUENTA         = r_cuenta;
    assign CHANGED        = r_changed;
    assign BANDERAENAUP   = (r_cuenta < c_max);
    assign BANDERAENADOWN = (r_cuenta > c_min);

endmodule
`default_nettype wire

// File: tb/tb_servo_ref_counter_ar.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_ref_counter_ar
// Brief    : Self-checking bench for servo_ref_counter_ar (default and 8-bit).
// Revision : 1.0
// ============================================================================
module tb_servo_ref_counter_ar;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ena      = 1'b0;
    logic       up       = 1'b0;
    logic       down     = 1'b0;
    logic       load     = 1'b0;
    logic [8:0] load_val = '0;

    logic [8:0] cuenta9;
    logic       up9, dn9, ch9;
    logic [7:0] cuenta8;
    logic       up8, dn8, ch8;

    always #5 clk = ~clk;

    servo_ref_counter_ar dut (
        .CLK(clk), .RST(rst), .ENA(ena), .UP(up), .DOWN(down), .LOAD(load),
        .LOAD_VAL(load_val), .CUENTA(cuenta9), .BANDERAENAUP(up9),
        .BANDERAENADOWN(dn9), .CHANGED(ch9)
    );

    servo_ref_counter_ar #(
        .WIDTH(8), .STEP(3), .MIN_VAL(10), .MAX_VAL(250), .INIT_VAL(100)
    ) dut8 (
        .CLK(clk), .RST(rst), .ENA(ena), .UP(up), .DOWN(down), .LOAD(load),
        .LOAD_VAL(load_val[7:0]), .CUENTA(cuenta8), .BANDERAENAUP(up8),
        .BANDERAENADOWN(dn8), .CHANGED(ch8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int step; int lo; int hi; int init; int hold; int rate;
    } prm_t;

    // Behavioural view: a press starts a run; k counts ticks since the run began.
    typedef struct {
        int cuenta; int prev; bit active; int run_dir; int k; bit changed;
    } mst_t;

    function automatic mst_t model_next(mst_t s, prm_t p, bit r, bit e, bit u,
                                        bit d, bit l, int lv);
        mst_t n = s;
        int   dir;
        bit   do_step = 1'b0;
        if (r) begin
            n.cuenta = p.init; n.prev = 0; n.active = 1'b0; n.k = 0;
            n.run_dir = 0; n.changed = 1'b0;
            return n;
        end
        dir = (u && !d) ? 1 : ((d && !u) ? 2 : 0);
        if (l) begin
            n.cuenta = (lv < p.lo) ? p.lo : ((lv > p.hi) ? p.hi : lv);
            n.active = 1'b0;
            n.prev   = dir;
        end else if (e) begin
            if (dir == 0) begin
                n.active = 1'b0;
            end else if (!s.active) begin
                if (dir != s.prev) begin
                    n.active = 1'b1; n.run_dir = dir; n.k = 0; do_step = 1'b1;
                end
            end else if (dir != s.run_dir) begin
                n.run_dir = dir; n.k = 0; do_step = 1'b1;
            end else begin
                n.k = s.k + 1;
                if (n.k == p.hold || (n.k > p.hold && (n.k - p.hold) % p.rate == 0))
                    do_step = 1'b1;
            end
            n.prev = dir;
            if (do_step) begin
                if (dir == 1)
                    n.cuenta = (s.cuenta + p.step > p.hi) ? p.hi : s.cuenta + p.step;
                else
                    n.cuenta = (s.cuenta - p.step < p.lo) ? p.lo : s.cuenta - p.step;
            end
        end
        n.changed = (n.cuenta != s.cuenta);
        return n;
    endfunction

    prm_t p9 = '{step: 5, lo: 20, hi: 340, init: 180, hold: 50, rate: 10};
    prm_t p8 = '{step: 3, lo: 10, hi: 250, init: 100, hold: 50, rate: 10};
    mst_t m9 = '{default: 0};
    mst_t m8 = '{default: 0};

    always @(posedge clk) begin
        m9 = model_next(m9, p9, rst, ena, up, down, load, int'(load_val));
        m8 = model_next(m8, p8, rst, ena, up, down, load, int'(load_val[7:0]));
        #1;
        chk("cuenta9",  int'(cuenta9), m9.cuenta);
        chk("changed9", int'(ch9),     int'(m9.changed));
        chk("flagup9",  int'(up9),     int'(m9.cuenta < p9.hi));
        chk("flagdn9",  int'(dn9),     int'(m9.cuenta > p9.lo));
        chk("cuenta8",  int'(cuenta8), m8.cuenta);
        chk("changed8", int'(ch8),     int'(m8.changed));
        chk("flagup8",  int'(up8),     int'(m8.cuenta < p8.hi));
        chk("flagdn8",  int'(dn8),     int'(m8.cuenta > p8.lo));
    end

    // One ENA tick with the given buttons, followed by one idle cycle.
    task automatic tick(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); ena = 1'b1; up = u; down = d;
            @(negedge clk); ena = 1'b0;
        end
    endtask

    task automatic do_load(input int v);
        @(negedge clk); load = 1'b1; load_val = 9'(v);
        @(negedge clk); load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_cuenta9", int'(cuenta9), 180);
        chk("rst_changed", int'(ch9), 0);
        chk("rst_flags", int'({up9, dn9}), 3);
        chk("rst_cuenta8", int'(cuenta8), 100);

        tick(1, 0, 1);
        chk("tap_up_pulse", int'(ch9), 1);
        tick(0, 0, 1);
        chk("tap_up", int'(cuenta9), 185);
        tick(0, 1, 1); tick(0, 0, 1);
        chk("tap_down", int'(cuenta9), 180);

        tick(1, 0, 81); tick(0, 0, 1);
        chk("auto_repeat", int'(cuenta9), 205);

        do_load(338);
        tick(1, 0, 1); tick(0, 0, 1);
        chk("clamp_hi", int'(cuenta9), 340);
        chk("flagup_hi", int'(up9), 0);
        tick(1, 0, 1);
        chk("clamp_no_pulse", int'(ch9), 0);
        tick(0, 0, 1);
        chk("clamp_hold", int'(cuenta9), 340);
        do_load(5);
        chk("load_lo", int'(cuenta9), 20);
        chk("flagdn_lo", int'(dn9), 0);

        do_load(180);
        tick(1, 1, 100); tick(0, 0, 1);
        chk("both_buttons", int'(cuenta9), 180);
        tick(1, 0, 10);
        chk("pre_reverse", int'(cuenta9), 185);
        tick(0, 1, 1);
        chk("reverse_step", int'(cuenta9), 180);
        tick(0, 1, 5); tick(0, 0, 1);
        chk("reverse_hold", int'(cuenta9), 180);

        do_load(245);
        tick(1, 0, 61);
        chk("repeat_260", int'(cuenta9), 260);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_mid_repeat", int'(cuenta9), 180);
        tick(1, 0, 1);
        chk("post_rst_step", int'(cuenta9), 185);

        @(negedge clk); ena = 1'b1; load = 1'b1; load_val = 9'd300; up = 1'b1;
        @(negedge clk); ena = 1'b0; load = 1'b0;
        chk("load_wins", int'(cuenta9), 300);
        tick(1, 0, 5);
        chk("load_no_refire", int'(cuenta9), 300);
        tick(0, 0, 1); tick(1, 0, 1); tick(0, 0, 1);
        chk("load_repress", int'(cuenta9), 305);

        do_load(13);
        chk("w8_load13", int'(cuenta8), 13);
        tick(0, 1, 1); tick(0, 0, 1);
        chk("w8_dec_clamp", int'(cuenta8), 10);
        tick(0, 1, 1); tick(0, 0, 1);
        chk("w8_dec_floor", int'(cuenta8), 10);
        do_load(248);
        tick(1, 0, 1); tick(0, 0, 1);
        chk("w8_inc_clamp", int'(cuenta8), 250);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
